// File: rtl/ac3_sel_sched.sv
// Round-robin scheduler granting one of four AC2 lanes per cycle into the AC3 accumulator.
// gnt is combinational in RUN; sel_w_en/acc_we follow one cycle after each accept.
module ac3_sel_sched #(
  parameter int M   = 16,
  parameter int Pa  = 8,
  parameter int Pw  = 8,
  parameter int MNO = 288,
  localparam int CW = $clog2(MNO + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [3:0]    req,
  output logic [3:0]    gnt,
  output logic [1:0]    sel_w_en,
  output logic          acc_we,
  output logic [CW-1:0] acc_cnt,
  output logic          busy,
  output logic          done
);

  if (MNO < 1 || M < 1 || Pa < 1 || Pw < 1) begin : g_param_chk
    $error("ac3_sel_sched: MNO, M, Pa and Pw must all be >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [CW-1:0] LAST_CNT = CW'(MNO - 1);

  state_t        state_q, state_d;
  logic [1:0]    rr_ptr_q, rr_ptr_d;
  logic [CW-1:0] acc_cnt_q, acc_cnt_d;
  logic          acc_we_q, acc_we_d;
  logic [1:0]    sel_q, sel_d;

  logic [1:0]    pick_idx;
  logic          pick_vld;
  logic [1:0]    scan_idx;

  // First requesting lane at or after rr_ptr, wrapping 3 -> 0.
  always_comb begin
    pick_idx = rr_ptr_q;
    pick_vld = 1'b0;
    scan_idx = rr_ptr_q;
    for (int k = 0; k < 4; k++) begin
      scan_idx = rr_ptr_q + 2'(k);
      if (!pick_vld && req[scan_idx]) begin
        pick_vld = 1'b1;
        pick_idx = scan_idx;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    acc_cnt_d = acc_cnt_q;
    acc_we_d  = 1'b0;
    sel_d     = sel_q;
    gnt       = 4'b0000;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_RUN;
          rr_ptr_d  = 2'd0;
          acc_cnt_d = '0;
        end
      end
      S_RUN: begin
        // Grant is suppressed under reset so no lane believes it transferred.
        if (pick_vld && !rst) begin
          gnt       = 4'b0001 << pick_idx;
          rr_ptr_d  = pick_idx + 2'd1;
          acc_cnt_d = acc_cnt_q + CW'(1);
          acc_we_d  = 1'b1;
          sel_d     = pick_idx;
          if (acc_cnt_q == LAST_CNT) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rr_ptr_q  <= 2'd0;
      acc_cnt_q <= '0;
      acc_we_q  <= 1'b0;
      sel_q     <= 2'd0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      acc_cnt_q <= acc_cnt_d;
      acc_we_q  <= acc_we_d;
      sel_q     <= sel_d;
    end
  end

  assign sel_w_en = sel_q;
  assign acc_we   = acc_we_q;
  assign acc_cnt  = acc_cnt_q;
  assign busy     = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done     = (state_q == S_DONE);

endmodule

// File: tb/tb_ac3_sel_sched.sv
// Two schedulers (MNO=6 and MNO=1) driven in lockstep and compared each cycle
// against a per-unit reference model of the arbitration rules.
module tb_ac3_sel_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start;
  logic [3:0] req;

  logic [3:0] gnt6, gnt1;
  logic [1:0] sel6, sel1;
  logic       we6, we1;
  logic [2:0] cnt6;
  logic [0:0] cnt1;
  logic       busy6, busy1, done6, done1;

  ac3_sel_sched #(.M(16), .Pa(8), .Pw(8), .MNO(6)) u_dut6 (
    .clk(clk), .rst(rst), .start(start), .req(req), .gnt(gnt6),
    .sel_w_en(sel6), .acc_we(we6), .acc_cnt(cnt6), .busy(busy6), .done(done6)
  );

  ac3_sel_sched #(.M(16), .Pa(8), .Pw(8), .MNO(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .req(req), .gnt(gnt1),
    .sel_w_en(sel1), .acc_we(we1), .acc_cnt(cnt1), .busy(busy1), .done(done1)
  );

  localparam int P_IDLE = 0, P_RUN = 1, P_DRAIN = 2, P_DONE = 3;

  int n_vec = 0;
  int n_mis = 0;
  int cyc   = 0;

  int         mno   [2];
  int         ph    [2];
  int         ptr   [2];
  int         cnt   [2];
  int         sel_m [2];
  logic       we_m  [2];
  logic [3:0] eg    [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] ref_gnt(input int u, input logic [3:0] rq, input logic r);
    if (r || ph[u] != P_RUN) return 4'b0000;
    for (int k = 0; k < 4; k++) begin
      int j;
      j = (ptr[u] + k) % 4;
      if (rq[j]) return 4'(1 << j);
    end
    return 4'b0000;
  endfunction

  task automatic advance(input int u, input logic r, input logic s, input logic [3:0] g);
    we_m[u] = 1'b0;
    if (r) begin
      ph[u] = P_IDLE; ptr[u] = 0; cnt[u] = 0; sel_m[u] = 0;
    end else begin
      case (ph[u])
        P_IDLE: if (s) begin ph[u] = P_RUN; ptr[u] = 0; cnt[u] = 0; end
        P_RUN: if (g != 4'b0000) begin
          int j;
          j = 0;
          for (int k = 0; k < 4; k++) if (g[k]) j = k;
          we_m[u]  = 1'b1;
          sel_m[u] = j;
          ptr[u]   = (j + 1) % 4;
          cnt[u]   = cnt[u] + 1;
          if (cnt[u] == mno[u]) ph[u] = P_DRAIN;
        end
        P_DRAIN: ph[u] = P_DONE;
        default: ph[u] = P_IDLE;
      endcase
    end
  endtask

  task automatic check_unit(input int u, input logic [3:0] g, input logic [1:0] s, input logic w,
                            input logic [31:0] c, input logic b, input logic d);
    chk($sformatf("u%0d_gnt@%0d", u, cyc),  32'(g), 32'(eg[u]));
    chk($sformatf("u%0d_sel@%0d", u, cyc),  32'(s), 32'(sel_m[u]));
    chk($sformatf("u%0d_we@%0d", u, cyc),   32'(w), 32'(we_m[u]));
    chk($sformatf("u%0d_cnt@%0d", u, cyc),  c,      32'(cnt[u]));
    chk($sformatf("u%0d_busy@%0d", u, cyc), 32'(b), 32'(ph[u] == P_RUN || ph[u] == P_DRAIN));
    chk($sformatf("u%0d_done@%0d", u, cyc), 32'(d), 32'(ph[u] == P_DONE));
  endtask

  task automatic step(input logic r, input logic s, input logic [3:0] q);
    @(posedge clk);
    #1;
    rst = r; start = s; req = q;
    for (int u = 0; u < 2; u++) eg[u] = ref_gnt(u, q, r);
    @(negedge clk);
    check_unit(0, gnt6, sel6, we6, 32'(cnt6), busy6, done6);
    check_unit(1, gnt1, sel1, we1, 32'(cnt1), busy1, done1);
    for (int u = 0; u < 2; u++) advance(u, r, s, eg[u]);
    cyc++;
  endtask

  initial begin
    rst = 1'b1; start = 1'b1; req = 4'hF;
    mno[0] = 6; mno[1] = 1;
    for (int u = 0; u < 2; u++) begin
      ph[u] = P_IDLE; ptr[u] = 0; cnt[u] = 0; sel_m[u] = 0; we_m[u] = 1'b0; eg[u] = 4'b0000;
    end

    // reset with start held, then idle
    repeat (2) step(1'b1, 1'b1, 4'hF);
    repeat (3) step(1'b0, 1'b0, 4'h0);
    chk("s1_busy", 32'(busy6), 32'd0);

    // all lanes requesting: full rotation, MNO=6
    step(1'b0, 1'b1, 4'h0);
    repeat (6) step(1'b0, 1'b0, 4'hF);
    step(1'b0, 1'b0, 4'hF);
    chk("s2_cnt", 32'(cnt6), 32'd6);
    chk("s2_sel", 32'(sel6), 32'd1);
    step(1'b0, 1'b0, 4'hF);
    chk("s2_done", 32'(done6), 32'd1);
    repeat (2) step(1'b0, 1'b0, 4'hF);

    // lanes 1/3 only, with a request gap mid-run
    step(1'b0, 1'b1, 4'hA);
    repeat (3) step(1'b0, 1'b0, 4'hA);
    repeat (3) step(1'b0, 1'b0, 4'h0);
    repeat (6) step(1'b0, 1'b0, 4'hA);

    // reset after three accepts, then a clean run
    step(1'b0, 1'b1, 4'h0);
    repeat (3) step(1'b0, 1'b0, 4'hF);
    step(1'b1, 1'b0, 4'hF);
    step(1'b0, 1'b0, 4'h0);
    chk("s4_cnt", 32'(cnt6), 32'd0);
    step(1'b0, 1'b1, 4'h0);
    repeat (9) step(1'b0, 1'b0, 4'hF);

    // start pulses while running and in DONE are ignored
    step(1'b0, 1'b1, 4'h0);
    step(1'b0, 1'b0, 4'h5);
    step(1'b0, 1'b1, 4'h5);
    repeat (5) step(1'b0, 1'b0, 4'h5);
    step(1'b0, 1'b1, 4'h5);
    repeat (2) step(1'b0, 1'b1, 4'h0);

    // MNO=1 single accept on lane 2
    step(1'b1, 1'b0, 4'h0);
    step(1'b0, 1'b1, 4'h0);
    step(1'b0, 1'b0, 4'b0100);
    step(1'b0, 1'b0, 4'h0);
    chk("s5_sel", 32'(sel1), 32'd2);
    chk("s5_we", 32'(we1), 32'd1);
    step(1'b0, 1'b0, 4'h0);
    chk("s5_done", 32'(done1), 32'd1);

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      logic       r, s;
      logic [3:0] q;
      r = ($urandom_range(0, 63) == 0);
      s = ($urandom_range(0, 7) == 0);
      q = ($urandom_range(0, 4) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      step(r, s, q);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
